// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and constants for the 3-to-8 pulse decoder.
//   CODE_W  : width of a binary code
//   OUT_W   : width of the one-hot output
//   state_e : pulse sequencer states
//   onehot(): binary code to one-hot vector
package decoder_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] vec;
    vec       = {OUT_W{1'b0}};
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush and occupancy count.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   flush           : empties the FIFO; overrides push and pop that cycle
//   push, push_data : write request (ignored when full)
//   pop, pop_data   : read request (ignored when empty); pop_data shows the head
//   level           : number of stored entries (0..DEPTH)
//   full, empty     : occupancy flags
module sync_fifo #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == {LVL_W{1'b0}});
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  // Next-state for storage, pointers and level; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      level_d  = {LVL_W{1'b0}};
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      mem_q    <= '{default: {WIDTH{1'b0}}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/decoder3to8_pulse.sv
// decoder3to8_pulse: queues 3-bit codes and emits each one as a one-hot pulse
// held for HOLD_CYCLES cycles, followed by one all-zero gap cycle.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : a code is offered on in_code
//   in_code    : binary index to decode
//   in_ready   : a code can be accepted this cycle
//   abort      : flushes the queue and the current pulse
//   out        : registered one-hot pulse, zero when idle
//   out_valid  : high exactly when out is non-zero
//   fifo_level : number of queued codes
module decoder3to8_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [CODE_W-1:0]           in_code,
  output logic                        in_ready,
  input  logic                        abort,
  output logic [OUT_W-1:0]            out,
  output logic                        out_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CODE_W-1:0]     fifo_head;

  // Full blocks acceptance even if a pop happens in the same cycle, so a
  // write can never land on an entry that is still queued.
  assign in_ready  = !fifo_full && !rst;
  assign fifo_push = in_valid && in_ready && !abort;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (fifo_push),
    .push_data (in_code),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer next-state: pop and load a pulse, count it down, then gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    fifo_pop = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      out_d   = {OUT_W{1'b0}};
    end else begin
      case (state_q)
        // IDLE and GAP behave the same for one cycle: out is already zero,
        // and a waiting code starts its pulse immediately.
        IDLE, GAP: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            out_d    = onehot(fifo_head);
            cnt_d    = HOLD_LOAD;
            state_d  = HOLD;
          end else begin
            out_d   = {OUT_W{1'b0}};
            cnt_d   = 8'd0;
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (cnt_q == 8'd0) begin
            out_d   = {OUT_W{1'b0}};
            state_d = GAP;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          out_d   = {OUT_W{1'b0}};
        end
      endcase
    end
    out_valid_d = |out_d;
  end

  // Sequencer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      out_q       <= {OUT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/decoder3to8_pulse.md
DECODER3TO8_PULSE -- requirements
Module: decoder3to8_pulse

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles each one-hot pulse is held (legal range 1..255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of queued codes (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a code is offered on in_code.
REQ-006 The block SHALL have port in_code, input, 3, the binary index to decode (0..7).
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block can accept a code this cycle.
REQ-008 The block SHALL have port abort, input, 1, a synchronous flush of the queue and the current pulse.
REQ-009 The block SHALL have port out, output, 8, the one-hot decoded pulse, or all-zero when idle.
REQ-010 The block SHALL have port out_valid, output, 1, asserted exactly when out is non-zero.
REQ-011 The block SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, the number of queued codes.

Function
REQ-012 A code SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal (fifo_level != FIFO_DEPTH) and rst=0.
REQ-013 When the queue is full, in_ready SHALL be 0 even if a pop occurs in the same cycle; no write SHALL ever overwrite a queued code.
REQ-014 The FSM SHALL have the states IDLE, HOLD and GAP.
REQ-015 IDLE: out=0; when fifo_level>0, the block SHALL pop the head code, load out=1<<code and counter=HOLD_CYCLES-1, and go to HOLD.
REQ-016 HOLD: out SHALL stay constant; counter SHALL decrement each cycle; at counter==0 the block SHALL go to GAP with out=0.
REQ-017 GAP: out=0 for exactly one cycle; if the queue is non-empty the block SHALL pop and go to HOLD directly, else it SHALL go to IDLE.
REQ-018 Latency: a code accepted into an empty queue at edge k, with the FSM in IDLE, SHALL produce out valid from edge k+1 through edge k+HOLD_CYCLES, and out=0 after edge k+HOLD_CYCLES+1.
REQ-019 Sustained throughput SHALL be one pulse per HOLD_CYCLES+1 cycles; codes SHALL be emitted in acceptance order, with none lost or duplicated.
REQ-020 A push and a pop in the same cycle SHALL leave fifo_level unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 HOLD_CYCLES=1 SHALL yield single-cycle pulses separated by one zero cycle.
REQ-022 When abort=1 at an edge, the block SHALL empty the queue, force out=0, set the state to IDLE and ignore any push in that cycle.
REQ-023 When abort and rst are both asserted, rst SHALL take precedence; the results are identical.

Reset
REQ-024 At an edge with rst=1, the block SHALL set state=IDLE, out=8'h00, out_valid=0, fifo_level=0, counter=0 and both pointers to 0.
REQ-025 Reset asserted mid-HOLD SHALL discard the pulse and all queued codes.
REQ-026 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.

Structure
REQ-027 Package decoder_pkg SHALL hold the state enum (IDLE/HOLD/GAP) and the constants CODE_W=3 and OUT_W=8.
REQ-028 The queue SHALL be a sub-module sync_fifo (parameterised width and depth, push/pop/flush, level output).
REQ-029 The decode SHALL be registered; out SHALL never be driven combinationally from in_code.

Verification (HOLD_CYCLES=4, FIFO_DEPTH=4)
REQ-030 Reset check: hold rst for 2 cycles -> out=8'h00, out_valid=0, fifo_level=0, in_ready=0, then in_ready=1 after release.
REQ-031 Single code: push 3'd5 at edge k -> out=8'h20 after edges k+1..k+4, then 8'h00 after edge k+5.
REQ-032 Back-to-back codes 0, 7, 2 -> out sequence 01x4, 00, 80x4, 00, 04x4, 00 with no extra gaps.
REQ-033 Overflow: hold in_valid=1 with codes 0..7 continuously -> fifo_level never exceeds 4, in_ready=0 whenever the level is 4, and all 8 pulses appear in order.
REQ-034 Abort: assert abort in the 2nd HOLD cycle with fifo_level=3 -> out=0 and fifo_level=0 on the next cycle, state IDLE, and no later pulse.
REQ-035 Reset mid-operation: assert rst in HOLD with a non-empty queue -> same result as REQ-030, and no stale code is emitted after release.
